// File: rtl/lockin_demod_accum.sv
// Lock-in demodulator / window accumulator.
// Removes the mid-scale offset from each unsigned ADC code, mixes it with
// in-phase and quadrature square-wave references (+1/-1), and sums the
// products over gapless windows of N = 2^LOG2_N accepted samples. Each
// completed window is published on i_out/q_out with a one-cycle
// result_valid pulse. Dropping enable or asserting reset throws away a
// partial window.
module lockin_demod_accum #(
    parameter int SAMPLE_W = 8,
    parameter int LOG2_N   = 8,
    localparam int ACC_W   = SAMPLE_W + 1 + LOG2_N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_W-1:0]     sample_in,
    input  logic                    sample_valid,
    input  logic                    ref_i,
    input  logic                    ref_q,
    output logic signed [ACC_W-1:0] i_out,
    output logic signed [ACC_W-1:0] q_out,
    output logic                    result_valid,
    output logic                    busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Counter value at which the sample being accepted is the last of the window.
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1'b1);

    state_t                    state_r;
    state_t                    state_next_s;
    logic [LOG2_N-1:0]         count_r;
    logic signed [ACC_W-1:0]   acc_i_r;
    logic signed [ACC_W-1:0]   acc_q_r;
    logic signed [ACC_W-1:0]   i_out_r;
    logic signed [ACC_W-1:0]   q_out_r;
    logic                      result_valid_r;

    logic signed [SAMPLE_W-1:0] centered_s;
    logic signed [SAMPLE_W:0]   ext_s;
    logic signed [SAMPLE_W:0]   term_i_s;
    logic signed [SAMPLE_W:0]   term_q_s;
    logic signed [ACC_W-1:0]    sum_i_s;
    logic signed [ACC_W-1:0]    sum_q_s;
    logic                       accept_s;
    logic                       done_s;
    logic                       clear_s;

    // Offset removal and mixing: subtracting mid-scale is an MSB flip; the
    // extra bit keeps the negation of the most negative code exact.
    always_comb begin
        centered_s = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
        ext_s      = (SAMPLE_W+1)'(centered_s);
        if (ref_i) begin
            term_i_s = ext_s;
        end else begin
            term_i_s = -ext_s;
        end
        if (ref_q) begin
            term_q_s = ext_s;
        end else begin
            term_q_s = -ext_s;
        end
        sum_i_s = acc_i_r + ACC_W'(term_i_s);
        sum_q_s = acc_q_r + ACC_W'(term_q_s);
    end

    // Next-state and datapath control: entering or leaving ACCUM clears the
    // window; the Nth accepted sample completes it.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = ACCUM;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_next_s = IDLE;
                    clear_s      = 1'b1;
                end else if (sample_valid) begin
                    state_next_s = ACCUM;
                    accept_s     = 1'b1;
                    if (count_r == CNT_LAST) begin
                        done_s = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                end else begin
                    state_next_s = ACCUM;
                end
            end
            default: begin
                state_next_s = IDLE;
                clear_s      = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accumulators, sample counter and published results.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r        <= {LOG2_N{1'b0}};
            acc_i_r        <= {ACC_W{1'b0}};
            acc_q_r        <= {ACC_W{1'b0}};
            i_out_r        <= {ACC_W{1'b0}};
            q_out_r        <= {ACC_W{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= done_s;
            if (clear_s || done_s) begin
                count_r <= {LOG2_N{1'b0}};
                acc_i_r <= {ACC_W{1'b0}};
                acc_q_r <= {ACC_W{1'b0}};
            end else if (accept_s) begin
                count_r <= count_r + CNT_ONE;
                acc_i_r <= sum_i_s;
                acc_q_r <= sum_q_s;
            end
            if (done_s) begin
                i_out_r <= sum_i_s;
                q_out_r <= sum_q_s;
            end
        end
    end

    assign i_out        = i_out_r;
    assign q_out        = q_out_r;
    assign result_valid = result_valid_r;
    assign busy         = (state_r == ACCUM);

endmodule
